cgra_job_scheduler: RTL and testbench

//  Shares one CGRA control plane between NUM_REQ packet-processing requesters (round-robin).
//  Per granted job: issues the table-loader start pulse with that job's entry counts, waits for loader done,

---
 rtl/cgra_job_scheduler.sv | 178 +++++++++++++++++
 tb/tb_cgra_job_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_job_scheduler.sv
// Round-robin job scheduler that shares one CGRA control plane: loader start, 4-phase stream-in, beat count.
// Optional watchdog (wdog_err output) enabled by defining CGRA_SCHED_WDOG_EN.
module cgra_job_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 8,
    parameter int CNT_W    = 16,
    parameter int WDOG_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_num_cfg,
    input  logic [NUM_REQ*ADDR_W-1:0] req_num_inb,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      job_done,
    output logic                      start_loader,
    output logic [ADDR_W-1:0]         num_entry_config_table,
    output logic [ADDR_W-1:0]         num_entry_inbound,
    input  logic                      loader_done,
    output logic                      start_stream_in,
    input  logic                      ready_stream_in,
    input  logic                      stream_valid,
    input  logic                      stream_last,
    output logic [CNT_W-1:0]          beat_cnt,
`ifdef CGRA_SCHED_WDOG_EN
    output logic                      wdog_err,
`endif
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || WDOG_CYC < 1) begin : g_bad_param
        $error("cgra_job_scheduler: NUM_REQ must be >= 2 and WDOG_CYC >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_WAIT_LD,
        S_HS,
        S_STREAM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ADDR_W-1:0]  cfg_q, cfg_d;
    logic [ADDR_W-1:0]  inb_q, inb_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand_idx;
    logic [ADDR_W-1:0]  win_cfg;
    logic [ADDR_W-1:0]  win_inb;

    // First requester at or after the pointer, searched cyclically.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_idx = PTR_W'((32'(ptr_q) + i) % 32'(NUM_REQ));
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
        win_cfg = req_num_cfg[win_idx*ADDR_W +: ADDR_W];
        win_inb = req_num_inb[win_idx*ADDR_W +: ADDR_W];
    end

`ifdef CGRA_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            werr_q, werr_d;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cfg_d   = cfg_q;
        inb_d   = inb_q;
        beat_d  = beat_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            S_IDLE: if (|req) state_d = S_ARB;
            S_ARB: begin
                if (win_found) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    cfg_d   = win_cfg;
                    inb_d   = win_inb;
                    beat_d  = '0;
                    ptr_d   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d = (win_cfg == '0 && win_inb == '0) ? S_HS : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD:    state_d = S_WAIT_LD;
            S_WAIT_LD: if (loader_done) state_d = S_HS;
            S_HS:      if (ready_stream_in) state_d = S_STREAM;
            S_STREAM: begin
                if (stream_valid) begin
                    if (beat_q != '1) beat_d = beat_q + 1'b1;
                    if (stream_last) state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef CGRA_SCHED_WDOG_EN
        // A normal transition always wins over a timeout landing in the same cycle.
        wdog_d = wdog_q;
        werr_d = 1'b0;
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (state_q == S_WAIT_LD || state_q == S_HS || state_q == S_STREAM) begin
            if (state_q == S_STREAM && stream_valid) begin
                wdog_d = '0;
            end else if (wdog_q == WD_W'(WDOG_CYC - 1)) begin
                wdog_d  = '0;
                werr_d  = 1'b1;
                state_d = S_DONE;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            cfg_q   <= '0;
            inb_q   <= '0;
            beat_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cfg_q   <= cfg_d;
            inb_q   <= inb_d;
            beat_q  <= beat_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef CGRA_SCHED_WDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
            werr_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            werr_q <= werr_d;
        end
    end
    assign wdog_err = werr_q;
`endif

    assign grant                  = grant_q;
    assign num_entry_config_table = cfg_q;
    assign num_entry_inbound      = inb_q;
    assign beat_cnt               = beat_q;
    assign start_loader           = (state_q == S_LOAD);
    assign start_stream_in        = (state_q == S_HS);
    assign job_done               = (state_q == S_DONE);
    assign busy                   = (state_q != S_IDLE);

endmodule

// File: tb/tb_cgra_job_scheduler.sv
// Directed and randomized jobs for cgra_job_scheduler, checked against a job-level round-robin model.
module tb_cgra_job_scheduler;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int CW = 4;
    localparam int WD = 16;
    localparam int SAT = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req;
    logic [NR*AW-1:0] req_num_cfg, req_num_inb;
    logic [NR-1:0]  grant;
    logic           job_done, start_loader, start_stream_in, busy;
    logic [AW-1:0]  num_entry_config_table, num_entry_inbound;
    logic           loader_done, ready_stream_in, stream_valid, stream_last;
    logic [CW-1:0]  beat_cnt;
`ifdef CGRA_SCHED_WDOG_EN
    logic           wdog_err;
`endif

    cgra_job_scheduler #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .CNT_W   (CW),
        .WDOG_CYC(WD)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req                   (req),
        .req_num_cfg           (req_num_cfg),
        .req_num_inb           (req_num_inb),
        .grant                 (grant),
        .job_done              (job_done),
        .start_loader          (start_loader),
        .num_entry_config_table(num_entry_config_table),
        .num_entry_inbound     (num_entry_inbound),
        .loader_done           (loader_done),
        .start_stream_in       (start_stream_in),
        .ready_stream_in       (ready_stream_in),
        .stream_valid          (stream_valid),
        .stream_last           (stream_last),
        .beat_cnt              (beat_cnt),
`ifdef CGRA_SCHED_WDOG_EN
        .wdog_err              (wdog_err),
`endif
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ref_ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NR-1:0] m);
        for (int k = 0; k < NR; k++) begin
            if (m[(ref_ptr + k) % NR]) return (ref_ptr + k) % NR;
        end
        return -1;
    endfunction

    // One complete job; abort_at >= 0 pulls reset low just before that beat.
    task automatic run_job(input logic [NR-1:0] mask, input logic [31:0] cfgv, input logic [31:0] inbv,
                           input int ld_dly, input int rdy_dly, input int nbeats,
                           input bit ld_in_load, input bit drop_req, input int abort_at,
                           output logic [NR-1:0] grant_seen);
        int w;
        int exp_beats;
        logic [AW-1:0] ec, ei;
        bit loaded;
        req_num_cfg = cfgv;
        req_num_inb = inbv;
        req = mask;
        w = pick(mask);
        ec = cfgv[w*AW +: AW];
        ei = inbv[w*AW +: AW];
        loaded = (ec != '0) || (ei != '0);
        exp_beats = (nbeats > SAT) ? SAT : nbeats;
        tick();
        chk("grant_latency", 32'(grant), 32'(0));
        chk("busy_arb", 32'(busy), 32'(1));
        tick();
        grant_seen = grant;
        chk("grant", 32'(grant), 32'(1) << w);
        chk("cnt_cfg", 32'(num_entry_config_table), 32'(ec));
        chk("cnt_inb", 32'(num_entry_inbound), 32'(ei));
        chk("beat_clear", 32'(beat_cnt), 32'(0));
        ref_ptr = (w + 1) % NR;
        req_num_cfg = $urandom;
        req_num_inb = $urandom;
        if (drop_req) req = '0;
        if (loaded) begin
            chk("start_loader", 32'(start_loader), 32'(1));
            if (ld_in_load) loader_done = 1'b1;
            tick();
            loader_done = 1'b0;
            chk("loader_one_pulse", 32'(start_loader), 32'(0));
            chk("ss_wait_ld", 32'(start_stream_in), 32'(0));
            for (int d = 0; d < ld_dly; d++) begin
                tick();
                chk("ss_wait_ld", 32'(start_stream_in), 32'(0));
            end
            loader_done = 1'b1;
            tick();
            loader_done = 1'b0;
            chk("ss_after_ld", 32'(start_stream_in), 32'(1));
        end else begin
            chk("no_loader", 32'(start_loader), 32'(0));
            chk("hs_direct", 32'(start_stream_in), 32'(1));
        end
        for (int d = 0; d < rdy_dly; d++) begin
            tick();
            chk("ss_hold", 32'(start_stream_in), 32'(1));
        end
        ready_stream_in = 1'b1;
        tick();
        chk("ss_drop", 32'(start_stream_in), 32'(0));
        ready_stream_in = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (i == abort_at) begin
                rst = 1'b0;
                req = '0;
                #1;
                chk("rst_grant", 32'(grant), 32'(0));
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_done", 32'(job_done), 32'(0));
                chk("rst_beats", 32'(beat_cnt), 32'(0));
                chk("rst_cfg", 32'(num_entry_config_table), 32'(0));
                chk("rst_ss", 32'(start_stream_in), 32'(0));
                ref_ptr = 0;
                tick();
                rst = 1'b1;
                tick();
                chk("rst_no_done", 32'(job_done), 32'(0));
                return;
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                stream_last = 1'($urandom);
                tick();
            end
            stream_valid = 1'b1;
            stream_last = (i == nbeats - 1);
            tick();
            stream_valid = 1'b0;
            stream_last = 1'b0;
            if (i != nbeats - 1) chk("no_early_done", 32'(job_done), 32'(0));
        end
        chk("job_done", 32'(job_done), 32'(1));
        chk("beat_cnt", 32'(beat_cnt), 32'(exp_beats));
        chk("cnt_cfg_held", 32'(num_entry_config_table), 32'(ec));
        chk("cnt_inb_held", 32'(num_entry_inbound), 32'(ei));
        tick();
        chk("done_pulse", 32'(job_done), 32'(0));
        chk("grant_clear", 32'(grant), 32'(0));
        chk("idle", 32'(busy), 32'(0));
        chk("beat_hold", 32'(beat_cnt), 32'(exp_beats));
    endtask

    initial begin
        logic [NR-1:0] gs;
        logic [NR-1:0] order [5];
        logic [NR-1:0] m;
        logic [31:0] cv, iv;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        rst = 1'b0;
        req = '0;
        req_num_cfg = '0;
        req_num_inb = '0;
        loader_done = 1'b0;
        ready_stream_in = 1'b0;
        stream_valid = 1'b0;
        stream_last = 1'b0;
        tick();
        tick();
        chk("reset_grant", 32'(grant), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_loader", 32'(start_loader), 32'(0));
        rst = 1'b1;
        tick();

        // Single job with loader, then a zero-count job that skips the loader.
        run_job(4'b0001, 32'h0000_0005, 32'h0000_0003, 2, 3, 4, 1'b1, 1'b0, -1, gs);
        run_job(4'b0100, 32'h0000_0000, 32'h0000_0000, 0, 1, 3, 1'b0, 1'b0, -1, gs);
        // Reset mid-stream with the pointer away from zero.
        run_job(4'b0010, 32'h0000_0700, 32'h0000_0100, 1, 0, 6, 1'b0, 1'b0, 2, gs);

        for (int j = 0; j < 5; j++) begin
            run_job(4'b1111, 32'h0403_0201, 32'h0000_0000, 0, 1, 2, 1'b0, 1'b0, -1, gs);
            chk("rr_order", 32'(gs), 32'(order[j]));
        end

        // Saturation of the beat counter.
        run_job(4'b1000, 32'h0100_0000, 32'h0200_0000, 0, 0, SAT + 5, 1'b0, 1'b0, -1, gs);

        for (int j = 0; j < 30; j++) begin
            m = NR'($urandom_range(1, (1 << NR) - 1));
            cv = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            iv = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            run_job(m, cv, iv, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(1, 20),
                    1'($urandom), 1'($urandom), -1, gs);
        end

`ifdef CGRA_SCHED_WDOG_EN
        begin
            int n;
            req = 4'b0001;
            req_num_cfg = 32'h0000_0001;
            req_num_inb = 32'h0;
            tick();
            tick();
            req = '0;
            tick();
            n = 0;
            while (job_done !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            chk("wdog_cycles", 32'(n), 32'(WD));
            chk("wdog_err", 32'(wdog_err), 32'(1));
            tick();
            chk("wdog_idle", 32'(busy), 32'(0));
            chk("wdog_err_pulse", 32'(wdog_err), 32'(0));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
